// File: rtl/registro_pipe_if.sv
// Valid/ready handshake bundle for registro_pipe: upstream beat channel and
// downstream beat channel of one pipeline.
interface registro_pipe_if #(
    parameter int WIDTH = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] datain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataout;

    // Master is the environment around the pipe (producer and consumer side).
    modport master (
        output in_valid,
        output datain,
        input  in_ready,
        input  out_valid,
        input  dataout,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  datain,
        output in_ready,
        output out_valid,
        output dataout,
        input  out_ready
    );
endinterface

// File: rtl/registro_pipe.sv
// Elastic register pipeline of DEPTH stages with bubble-collapsing valid/ready
// flow control, global enable, synchronous flush and an occupancy counter.
module registro_pipe #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       flush,
    registro_pipe_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_p [DEPTH];
    logic [WIDTH-1:0] src    [DEPTH];
    logic [DEPTH-1:0] vld_p;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] cap;
    logic             ld0;
    logic             in_fire;
    logic             out_fire;

    // Ready chain, walked from the output back: a stage may load when it is
    // empty or when everything downstream of it can move.
    always_comb begin
        logic chain;
        chain = bus.out_ready;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = vld_p[i] & chain;
            chain  = chain | ~vld_p[i];
        end
        ld0 = chain;
    end

    assign bus.in_ready  = rst_n & en & ~flush & ld0;
    assign bus.out_valid = en & vld_p[DEPTH-1];
    assign bus.dataout   = data_p[DEPTH-1];

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready & ~flush;

    always_comb begin
        cap    = '0;
        cap[0] = in_fire;
        src[0] = bus.datain;
        for (int i = 1; i < DEPTH; i++) begin
            cap[i] = adv[i-1];
            src[i] = data_p[i-1];
        end
    end

    // Stage registers: flush only drops valid bits, data stays where it is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_p[i] <= '0;
            end
        end else if (en) begin
            if (flush) begin
                vld_p <= '0;
            end else begin
                vld_p <= cap | (vld_p & ~adv);
                for (int i = 0; i < DEPTH; i++) begin
                    if (cap[i]) begin
                        data_p[i] <= src[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            if (flush) begin
                count <= '0;
            end else if (in_fire && !out_fire) begin
                count <= count + CW'(1);
            end else if (out_fire && !in_fire) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_registro_pipe.sv
// Bench for registro_pipe: three parameterisations share one stimulus stream and
// are checked one at a time against a queue-based occupancy/order model.
module tb_registro_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] datain;

    int          sel;
    int          dep;
    logic [31:0] mask;

    logic        o_in_ready;
    logic        o_out_valid;
    logic [31:0] o_dataout;
    logic [7:0]  o_count;

    int          checks = 0;
    int          fails  = 0;

    logic [31:0] q[$];
    int          cyc;
    int          nin;
    int          nout;
    int          first_in;
    int          first_out;
    int          last_out;
    int          max_cnt;
    logic        last_in_fire;

    always #5 clk = ~clk;

    registro_pipe_if #(.WIDTH(14)) b0 ();
    registro_pipe_if #(.WIDTH(1))  b1 ();
    registro_pipe_if #(.WIDTH(32)) b2 ();
    logic [2:0] cnt0;
    logic [0:0] cnt1;
    logic [3:0] cnt2;

    assign b0.in_valid  = in_valid;
    assign b0.datain    = datain[13:0];
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.datain    = datain[0:0];
    assign b1.out_ready = out_ready;
    assign b2.in_valid  = in_valid;
    assign b2.datain    = datain;
    assign b2.out_ready = out_ready;

    registro_pipe #(.WIDTH(14), .DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .bus(b0), .count(cnt0));
    registro_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .bus(b1), .count(cnt1));
    registro_pipe #(.WIDTH(32), .DEPTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .bus(b2), .count(cnt2));

    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_dataout   = '0;
        o_count     = '0;
        case (sel)
            0: begin
                o_in_ready      = b0.in_ready;
                o_out_valid     = b0.out_valid;
                o_dataout[13:0] = b0.dataout;
                o_count[2:0]    = cnt0;
            end
            1: begin
                o_in_ready     = b1.in_ready;
                o_out_valid    = b1.out_valid;
                o_dataout[0:0] = b1.dataout;
                o_count[0:0]   = cnt1;
            end
            default: begin
                o_in_ready   = b2.in_ready;
                o_out_valid  = b2.out_valid;
                o_dataout    = b2.dataout;
                o_count[3:0] = cnt2;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", sel, tag, act, exp);
        end
    endtask

    task automatic mark();
        nin = 0; nout = 0; first_in = -1; first_out = -1; last_out = -1; max_cnt = 0;
    endtask

    // One clock cycle: drive, check against the model at the falling edge,
    // then advance the model by the transfers the handshake rules imply.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic e, input logic fl);
        logic exp_ready;
        logic in_fire;
        logic out_fire;
        in_valid  = iv;
        datain    = d;
        out_ready = ordy;
        en        = e;
        flush     = fl;
        @(negedge clk);
        exp_ready = e & ~fl & ((q.size() < dep) | ordy);
        chk("in_ready", {31'b0, o_in_ready}, {31'b0, exp_ready});
        chk("count", 32'(o_count), 32'(q.size()));
        if (!e || q.size() == 0) chk("out_valid_idle", {31'b0, o_out_valid}, 32'd0);
        if (o_out_valid && q.size() != 0) chk("dataout", o_dataout, q[0]);
        in_fire  = iv & exp_ready;
        out_fire = o_out_valid & ordy & e & ~fl;
        if (e && fl) begin
            q.delete();
        end else if (e) begin
            if (out_fire && q.size() != 0) void'(q.pop_front());
            if (in_fire) q.push_back(d & mask);
        end
        if (in_fire) begin
            nin++;
            if (first_in < 0) first_in = cyc;
        end
        if (o_out_valid && first_out < 0) first_out = cyc;
        if (out_fire) begin
            nout++;
            last_out = cyc;
        end
        if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
        last_in_fire = in_fire;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && q.size() != 0; k++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic run_cfg();
        int          idx;
        int          nb;
        logic [31:0] dsave;

        rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        datain = 32'h1;
        q.delete();
        cyc = 0;
        #2;
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, o_in_ready}, 32'd0);
        chk("rst_dataout", o_dataout, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pass-through: DEPTH+1 back-to-back beats with the sink always ready.
        mark();
        for (int k = 0; k < dep + 1; k++) cycle(1'b1, 32'(k + 1), 1'b1, 1'b1, 1'b0);
        drain(dep + 6);
        chk("pt_in", nin, dep + 1);
        chk("pt_latency", first_out - first_in, dep);
        chk("pt_out", nout, dep + 1);
        chk("pt_consecutive", last_out - first_out, dep);
        chk("pt_maxcount", max_cnt, dep);

        // Back-pressure: offer DEPTH+2 beats into a stalled sink.
        mark();
        idx = 1;
        for (int k = 0; k < dep + 4; k++) begin
            cycle(1'b1, 32'(idx), 1'b0, 1'b1, 1'b0);
            if (last_in_fire) idx++;
        end
        chk("bp_accepted", nin, dep);
        chk("bp_count", 32'(o_count), dep);
        chk("bp_in_ready", {31'b0, o_in_ready}, 32'd0);
        for (int k = 0; k < 3 * dep + 10 && nout < dep + 2; k++) begin
            cycle(idx <= dep + 2, 32'(idx), 1'b1, 1'b1, 1'b0);
            if (last_in_fire) idx++;
        end
        chk("bp_out", nout, dep + 2);

        // Enable freeze with up to two beats held.
        mark();
        nb = (dep < 2) ? dep : 2;
        for (int k = 0; k < nb; k++) cycle(1'b1, 32'(16 + k), 1'b0, 1'b1, 1'b0);
        dsave = o_dataout;
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h2a, 1'b1, 1'b0, 1'b0);
        chk("frz_count", 32'(o_count), nb);
        chk("frz_dataout", o_dataout, dsave);
        drain(dep + 6);
        chk("frz_out", nout, nb);

        // Flush a full pipe while a new beat is offered.
        mark();
        for (int k = 0; k < dep; k++) cycle(1'b1, 32'(48 + k), 1'b0, 1'b1, 1'b0);
        chk("fl_full", 32'(o_count), dep);
        dsave = o_dataout;
        cycle(1'b1, 32'h3f, 1'b1, 1'b1, 1'b1);
        chk("fl_count", 32'(o_count), 32'd0);
        chk("fl_out_valid", {31'b0, o_out_valid}, 32'd0);
        chk("fl_dataout_kept", o_dataout, dsave);
        cycle(1'b1, 32'h41, 1'b1, 1'b1, 1'b0);
        drain(dep + 6);
        chk("fl_after_out", nout, 1);

        // Flush is ignored while enable is low.
        mark();
        cycle(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("fl_en_low", 32'(o_count), 32'd1);
        drain(dep + 6);
        chk("fl_en_low_out", nout, 1);

        // Asynchronous reset between edges.
        mark();
        nb = (dep < 3) ? dep : 3;
        for (int k = 0; k < nb; k++) cycle(1'b1, 32'(80 + k), 1'b0, 1'b1, 1'b0);
        chk("ar_pre", 32'(o_count), nb);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(o_count), 32'd0);
        chk("ar_dataout", o_dataout, 32'd0);
        chk("ar_out_valid", {31'b0, o_out_valid}, 32'd0);
        chk("ar_in_ready", {31'b0, o_in_ready}, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mark();
        cycle(1'b1, 32'h66, 1'b1, 1'b1, 1'b0);
        chk("ar_first_accept", nin, 1);
        drain(dep + 6);
        chk("ar_after_out", nout, 1);

        // Randomised traffic with enable and flush activity.
        mark();
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
        end
        drain(dep + 10);
        chk("rnd_drained", 32'(o_count), 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            sel  = s;
            dep  = (s == 0) ? 4 : (s == 1) ? 1 : 8;
            mask = (s == 0) ? 32'h3fff : (s == 1) ? 32'h1 : 32'hffff_ffff;
            run_cfg();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/registro_pipe.md
REGISTRO_PIPE -- requirements
Module: registro_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 14, meaning data width in bits (minimum 1).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning number of pipeline stages (minimum 1).
REQ-003 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port en  input  1  global enable; low freezes the whole pipe.
REQ-006 The module SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-007 The module SHALL have port in_valid  input  1  upstream beat present on datain.
REQ-008 The module SHALL have port in_ready  output  1  pipe accepts a beat this cycle.
REQ-009 The module SHALL have port datain  input  WIDTH  upstream data.
REQ-010 The module SHALL have port out_valid  output  1  dataout holds a valid beat.
REQ-011 The module SHALL have port out_ready  input  1  downstream accepts a beat this cycle.
REQ-012 The module SHALL have port dataout  output  WIDTH  last-stage data, registered.
REQ-013 The module SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages (0..DEPTH).

Function
REQ-014 Each stage i (0..DEPTH-1) SHALL hold a data register and a valid bit; stage 0 is the input stage, stage DEPTH-1 drives dataout/out_valid.
REQ-015 Transfers SHALL occur only on a rising edge where the respective valid and ready are both high: input when in_valid & in_ready, output when out_valid & out_ready.
REQ-016 Stage DEPTH-1 SHALL be advancing when its valid bit is high and out_ready is high; stage i<DEPTH-1 SHALL be advancing when its valid bit is high and stage i+1 can load.
REQ-017 Stage i SHALL be able to load when its valid bit is low or stage i is advancing (bubble-collapsing, combinational ready chain).
REQ-018 in_ready SHALL equal en & ~flush & (stage 0 can load).
REQ-019 out_valid SHALL equal en & valid bit of stage DEPTH-1.
REQ-020 A stage that loads SHALL capture the previous stage's data (stage 0: datain) and set valid; a stage that advances without loading SHALL clear valid; a stage not loading SHALL keep its data register unchanged.
REQ-021 Latency SHALL be DEPTH cycles from input transfer to out_valid when empty and out_ready is held high; sustained throughput SHALL be one beat per cycle.
REQ-022 With out_ready low the pipe SHALL fill to exactly DEPTH beats, then in_ready SHALL go low; no beat SHALL be overwritten or lost.
REQ-023 Beats SHALL leave in strict arrival order; no duplication.
REQ-024 When en is low no register SHALL change, in_ready and out_valid SHALL be low, and count SHALL hold.
REQ-025 When flush is high with en high, all valid bits SHALL clear on that edge, any beat on datain SHALL be dropped, data registers SHALL keep their values; flush SHALL have priority over all transfers.
REQ-026 When flush is high with en low, nothing SHALL change (en has priority).
REQ-027 count SHALL be a registered value equal to the number of set valid bits; it SHALL increment on input-only transfer, decrement on output-only transfer, hold on simultaneous input and output transfer, and go to 0 on flush.
REQ-028 count SHALL never exceed DEPTH and never wrap below 0.

Reset
REQ-029 When rst_n is low, all valid bits SHALL clear immediately, without waiting for clk.
REQ-030 During reset all data registers and dataout SHALL be 0, count SHALL be 0, out_valid and in_ready SHALL be 0.
REQ-031 Reset asserted mid-transfer SHALL discard all beats; the first rising edge with rst_n high SHALL accept input if en is high.

Verification
REQ-032 Pass-through test: DEPTH=4, en=1, out_ready=1, input 14'h0001..14'h0005 on consecutive cycles -> out_valid rises 4 cycles after the first transfer; dataout 0001..0005 on consecutive cycles; count stays at 4 while the stream is in flight.
REQ-033 Back-pressure test: out_ready=0, offer 6 beats -> in_ready low after 4 accepted, count=4; then out_ready=1 -> 1,2,3,4 emerge in order, then beats 5,6 are accepted and emerge.
REQ-034 Enable-freeze test: pipe holds 2 beats; en=0 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count=2 unchanged; en=1 -> same beats resume in order.
REQ-035 Flush test: pipe full (count=4), assert flush with in_valid=1 for one cycle -> next cycle count=0, out_valid=0, no output transfer, the input beat is dropped.
REQ-036 Async reset test: rst_n low between clk edges with count=3 -> count=0, dataout=0, out_valid=0 before the next edge.
REQ-037 Parameter test: WIDTH=1 with DEPTH=1, and WIDTH=32 with DEPTH=8 -> REQ-032 and REQ-033 pass with the scaled latency and capacity.
